ram_arb_mx: RTL and testbench

//  Single-clock synchronous RAM shared by CChCnt requester channels through a round-robin arbiter.

---
 rtl/ram_pkg.sv | 29 ++
 rtl/ram_arb_mx_if.sv | 26 ++
 rtl/ram_rr_arb.sv | 53 +++++
 rtl/ram_arb_mx.sv | 126 ++++++++++++
 tb/tb_ram_arb_mx.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared helpers for the multi-channel arbitrated RAM: byte-lane count,
// one-hot/index conversion, round-robin index wrap and a zero-data constant.
package ram_pkg;

  localparam int unsigned CMaxCh      = 16;
  localparam int unsigned CMaxDataLen = 1024;

  localparam logic [CMaxDataLen-1:0] CZeroData = '0;

  function automatic int unsigned byte_cnt(input int unsigned data_len);
    return data_len / 8;
  endfunction

  function automatic logic [3:0] onehot_to_idx(input logic [CMaxCh-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < int'(CMaxCh); i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

  // Next channel index in ascending order, wrapping n-1 -> 0.
  function automatic logic [3:0] wrap_inc(input logic [3:0] idx, input int unsigned n);
    if ({28'd0, idx} + 32'd1 >= n) return 4'd0;
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/ram_arb_mx_if.sv
// Request/response bundle between the requester channels and the shared RAM.
interface ram_arb_mx_if #(
  parameter int unsigned CAddrLen = 11,
  parameter int unsigned CDataLen = 32,
  parameter int unsigned CChCnt   = 4
);
  logic                         AClkHEn;
  logic [CChCnt*CAddrLen-1:0]   AAddr;
  logic [CChCnt*CDataLen-1:0]   AMosi;
  logic [CChCnt*CDataLen/8-1:0] AByteEn;
  logic [CChCnt-1:0]            AWrEn;
  logic [CChCnt-1:0]            ARdEn;
  logic [CChCnt-1:0]            AAck;
  logic [CDataLen-1:0]          AMiso;
  logic [CChCnt-1:0]            AMisoVld;

  modport master (
    output AClkHEn, AAddr, AMosi, AByteEn, AWrEn, ARdEn,
    input  AAck, AMiso, AMisoVld
  );

  modport slave (
    input  AClkHEn, AAddr, AMosi, AByteEn, AWrEn, ARdEn,
    output AAck, AMiso, AMisoVld
  );
endinterface

// File: rtl/ram_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer just past the winner on every enabled grant.
module ram_rr_arb
  import ram_pkg::*;
#(
  parameter int unsigned CChCnt = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [CChCnt-1:0] req_i,
  output logic [CChCnt-1:0] gnt_o,
  output logic [3:0]        gnt_idx_o,
  output logic              gnt_vld_o
);

  logic [3:0]        ptr_q, ptr_d;
  logic [CMaxCh-1:0] req16;
  logic [CMaxCh-1:0] gnt16;
  logic [3:0]        cand;
  logic              found;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    req16 = '0;
    req16[CChCnt-1:0] = req_i;
    gnt16 = '0;
    found = 1'b0;
    cand  = ptr_q;
    for (int k = 0; k < int'(CChCnt); k++) begin
      if (!found && req16[cand]) begin
        found       = 1'b1;
        gnt16[cand] = 1'b1;
      end
      cand = wrap_inc(cand, CChCnt);
    end
    if (!(en_i && rst_ni)) gnt16 = '0;
  end

  assign gnt_o     = gnt16[CChCnt-1:0];
  assign gnt_idx_o = onehot_to_idx(gnt16);
  assign gnt_vld_o = |gnt16;
  assign ptr_d     = gnt_vld_o ? wrap_inc(gnt_idx_o, CChCnt) : ptr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)   ptr_q <= '0;
    else if (en_i) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_arb_mx.sv
// Single-port RAM shared by CChCnt channels via round-robin arbitration, with
// per-byte write enables, write-first read data and an optional output stage.
module ram_arb_mx
  import ram_pkg::*;
#(
  parameter int unsigned CAddrLen = 11,
  parameter int unsigned CDataLen = 32,
  parameter int unsigned CChCnt   = 4,
  parameter int unsigned COutReg  = 0
) (
  input  logic         AClkH,
  input  logic         AResetHN,
  ram_arb_mx_if.slave  bus
);

  localparam int unsigned CByteCnt = byte_cnt(CDataLen);

  typedef struct packed {
    logic                wr;
    logic                rd;
    logic [CAddrLen-1:0] addr;
    logic [CDataLen-1:0] data;
    logic [CByteCnt-1:0] be;
  } req_t;

  logic [CChCnt-1:0]   req;
  logic [CChCnt-1:0]   gnt;
  logic [3:0]          gnt_idx;
  logic                gnt_vld;
  req_t                sel;
  logic [CDataLen-1:0] old_word;
  logic [CDataLen-1:0] merged;

  assign req = bus.AWrEn | bus.ARdEn;

  ram_rr_arb #(.CChCnt(CChCnt)) u_arb (
    .clk_i     (AClkH),
    .rst_ni    (AResetHN),
    .en_i      (bus.AClkHEn),
    .req_i     (req),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign bus.AAck = gnt;

  always_comb begin
    sel = '0;
    for (int i = 0; i < int'(CChCnt); i++) begin
      if (gnt_vld && ({28'd0, gnt_idx} == 32'(i))) begin
        sel.wr   = bus.AWrEn[i];
        sel.rd   = bus.ARdEn[i];
        sel.addr = bus.AAddr[i*CAddrLen +: CAddrLen];
        sel.data = bus.AMosi[i*CDataLen +: CDataLen];
        sel.be   = bus.AByteEn[i*CByteCnt +: CByteCnt];
      end
    end
  end

  logic [CDataLen-1:0] mem_q [0:(2**CAddrLen)-1];

  assign old_word = mem_q[sel.addr];

  // Write-first: a combined write+read sees the freshly written bytes.
  always_comb begin
    merged = old_word;
    if (sel.wr) begin
      for (int j = 0; j < int'(CByteCnt); j++) begin
        if (sel.be[j]) merged[8*j +: 8] = sel.data[8*j +: 8];
      end
    end
  end

  // NOTE: the RAM array is deliberately left out of reset so it maps onto
  // block RAM; contents survive AResetHN.
  always_ff @(posedge AClkH) begin
    if (bus.AClkHEn && gnt_vld && sel.wr) begin
      for (int j = 0; j < int'(CByteCnt); j++) begin
        if (sel.be[j]) mem_q[sel.addr][8*j +: 8] <= sel.data[8*j +: 8];
      end
    end
  end

  logic [CChCnt-1:0]   s1_vld_q, s1_vld_d;
  logic [CDataLen-1:0] s1_data_q, s1_data_d;
  logic                rd_hit;

  // Data is stored as zero whenever no read completes, so AMiso is already
  // gated when the tag is empty.
  assign rd_hit    = gnt_vld && sel.rd;
  assign s1_vld_d  = rd_hit ? gnt : '0;
  assign s1_data_d = rd_hit ? merged : CZeroData[CDataLen-1:0];

  always_ff @(posedge AClkH) begin
    if (!AResetHN) begin
      s1_vld_q  <= '0;
      s1_data_q <= '0;
    end else if (bus.AClkHEn) begin
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
    end
  end

  if (COutReg != 0) begin : g_oreg
    logic [CChCnt-1:0]   s2_vld_q;
    logic [CDataLen-1:0] s2_data_q;

    always_ff @(posedge AClkH) begin
      if (!AResetHN) begin
        s2_vld_q  <= '0;
        s2_data_q <= '0;
      end else if (bus.AClkHEn) begin
        s2_vld_q  <= s1_vld_q;
        s2_data_q <= s1_data_q;
      end
    end

    assign bus.AMisoVld = s2_vld_q;
    assign bus.AMiso    = s2_data_q;
  end else begin : g_noreg
    assign bus.AMisoVld = s1_vld_q;
    assign bus.AMiso    = s1_data_q;
  end

endmodule

// File: tb/tb_ram_arb_mx.sv
// Directed bench: one DUT without and one with the output register, both fed
// the same requests; expected values are hand-computed constants.
module tb_ram_arb_mx;

  localparam int unsigned CAW = 11;
  localparam int unsigned CDW = 32;
  localparam int unsigned CCH = 4;

  logic clk;
  logic rst_n;
  logic en;
  logic [CCH*CAW-1:0]   addr;
  logic [CCH*CDW-1:0]   mosi;
  logic [CCH*CDW/8-1:0] be;
  logic [CCH-1:0]       wr;
  logic [CCH-1:0]       rd;

  int total = 0;
  int bad   = 0;

  ram_arb_mx_if #(.CAddrLen(CAW), .CDataLen(CDW), .CChCnt(CCH)) if0 ();
  ram_arb_mx_if #(.CAddrLen(CAW), .CDataLen(CDW), .CChCnt(CCH)) if1 ();

  assign if0.AClkHEn = en;
  assign if0.AAddr   = addr;
  assign if0.AMosi   = mosi;
  assign if0.AByteEn = be;
  assign if0.AWrEn   = wr;
  assign if0.ARdEn   = rd;
  assign if1.AClkHEn = en;
  assign if1.AAddr   = addr;
  assign if1.AMosi   = mosi;
  assign if1.AByteEn = be;
  assign if1.AWrEn   = wr;
  assign if1.ARdEn   = rd;

  ram_arb_mx #(.CAddrLen(CAW), .CDataLen(CDW), .CChCnt(CCH), .COutReg(0)) u_dut0 (
    .AClkH    (clk),
    .AResetHN (rst_n),
    .bus      (if0)
  );

  ram_arb_mx #(.CAddrLen(CAW), .CDataLen(CDW), .CChCnt(CCH), .COutReg(1)) u_dut1 (
    .AClkH    (clk),
    .AResetHN (rst_n),
    .bus      (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic w, input logic r, input logic [CAW-1:0] a,
                       input logic [CDW-1:0] d, input logic [3:0] b);
    wr[ch]           = w;
    rd[ch]           = r;
    addr[ch*CAW +: CAW] = a;
    mosi[ch*CDW +: CDW] = d;
    be[ch*4 +: 4]       = b;
  endtask

  task automatic idle();
    wr = '0;
    rd = '0;
    be = '0;
  endtask

  logic [3:0]  exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [31:0] exp_d [4] = '{32'hDEADBEEF, 32'h11BB33DD, 32'hDEADBEEF, 32'h11BB33DD};

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    addr  = '0;
    mosi  = '0;
    idle();

    // Reset: a pending request must not be acknowledged.
    drive(0, 1'b1, 1'b0, 11'd5, 32'hDEADBEEF, 4'hF);
    tick();
    tick();
    check("rst_ack0", if0.AAck, 4'b0000);
    check("rst_ack1", if1.AAck, 4'b0000);
    check("rst_vld0", if0.AMisoVld, 4'b0000);
    check("rst_miso0", if0.AMiso, 32'h0);
    check("rst_vld1", if1.AMisoVld, 4'b0000);

    // Full-word write then read on ch0.
    rst_n = 1'b1;
    #1;
    check("wr_ack", if0.AAck, 4'b0001);
    tick();
    drive(0, 1'b0, 1'b1, 11'd5, 32'h0, 4'h0);
    #1;
    check("rd_ack", if0.AAck, 4'b0001);
    tick();
    idle();
    check("rd_vld0", if0.AMisoVld, 4'b0001);
    check("rd_miso0", if0.AMiso, 32'hDEADBEEF);
    check("rd_vld1_early", if1.AMisoVld, 4'b0000);
    tick();
    check("rd_vld1", if1.AMisoVld, 4'b0001);
    check("rd_miso1", if1.AMiso, 32'hDEADBEEF);
    check("rd_vld0_drop", if0.AMisoVld, 4'b0000);
    check("rd_miso0_zero", if0.AMiso, 32'h0);

    // Byte enables on ch1 addr 9, including a no-op BE=0 write.
    drive(1, 1'b1, 1'b0, 11'd9, 32'h11223344, 4'hF);
    tick();
    drive(1, 1'b1, 1'b0, 11'd9, 32'hAABBCCDD, 4'h5);
    tick();
    drive(1, 1'b1, 1'b0, 11'd9, 32'hFFFFFFFF, 4'h0);
    tick();
    drive(1, 1'b0, 1'b1, 11'd9, 32'h0, 4'h0);
    #1;
    check("be_ack", if0.AAck, 4'b0010);
    tick();
    idle();
    check("be_vld0", if0.AMisoVld, 4'b0010);
    check("be_miso0", if0.AMiso, 32'h11BB33DD);

    // Round robin from pointer 0 with all four channels reading continuously.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(0, 1'b0, 1'b1, 11'd5, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b1, 11'd9, 32'h0, 4'h0);
    drive(2, 1'b0, 1'b1, 11'd5, 32'h0, 4'h0);
    drive(3, 1'b0, 1'b1, 11'd9, 32'h0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_ack", if0.AAck, exp_g[k]);
      tick();
      check("rr_vld", if0.AMisoVld, exp_g[k]);
      check("rr_data", if0.AMiso, exp_d[k % 4]);
    end
    idle();
    tick();

    // Write-first merge on ch2 addr 7.
    drive(2, 1'b1, 1'b0, 11'd7, 32'h0, 4'hF);
    tick();
    drive(2, 1'b1, 1'b1, 11'd7, 32'h000000FF, 4'h1);
    #1;
    check("wf_ack", if0.AAck, 4'b0100);
    tick();
    check("wf_vld0", if0.AMisoVld, 4'b0100);
    check("wf_miso0", if0.AMiso, 32'h000000FF);
    drive(2, 1'b1, 1'b1, 11'd7, 32'h0000AB00, 4'h2);
    tick();
    check("wf_merge", if0.AMiso, 32'h0000ABFF);
    idle();
    tick();

    // Clock-enable stall of three cycles with a read in flight.
    drive(0, 1'b0, 1'b1, 11'd5, 32'h0, 4'h0);
    tick();
    idle();
    en = 1'b0;
    drive(1, 1'b0, 1'b1, 11'd9, 32'h0, 4'h0);
    #1;
    check("stall_ack", if0.AAck, 4'b0000);
    tick();
    check("stall_vld1_a", if1.AMisoVld, 4'b0000);
    tick();
    tick();
    check("stall_vld1_b", if1.AMisoVld, 4'b0000);
    check("stall_hold_vld0", if0.AMisoVld, 4'b0001);
    check("stall_hold_miso0", if0.AMiso, 32'hDEADBEEF);
    idle();
    en = 1'b1;
    tick();
    check("stall_vld1", if1.AMisoVld, 4'b0001);
    check("stall_miso1", if1.AMiso, 32'hDEADBEEF);
    check("stall_vld0_drop", if0.AMisoVld, 4'b0000);

    // Reset right after a read grant discards the pending result.
    drive(1, 1'b0, 1'b1, 11'd9, 32'h0, 4'h0);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    check("mid_vld1", if1.AMisoVld, 4'b0000);
    check("mid_miso1", if1.AMiso, 32'h0);
    check("mid_vld0", if0.AMisoVld, 4'b0000);
    rst_n = 1'b1;
    tick();
    check("mid_vld1_after", if1.AMisoVld, 4'b0000);
    drive(0, 1'b0, 1'b1, 11'd5, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b1, 11'd9, 32'h0, 4'h0);
    drive(2, 1'b0, 1'b1, 11'd5, 32'h0, 4'h0);
    drive(3, 1'b0, 1'b1, 11'd9, 32'h0, 4'h0);
    #1;
    check("mid_ptr0", if1.AAck, 4'b0001);
    idle();
    drive(1, 1'b0, 1'b1, 11'd9, 32'h0, 4'h0);
    #1;
    check("mid_ack1", if1.AAck, 4'b0010);
    tick();
    idle();
    tick();
    check("mid_keep_vld1", if1.AMisoVld, 4'b0010);
    check("mid_keep_miso1", if1.AMiso, 32'h11BB33DD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
